// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, the hardwired zero register,
// the ALU opcode type and the operand-forwarding select encoding.
package pipe_pkg;

  localparam int DATA_W   = 64;
  localparam int ZERO_REG = 31;

  typedef logic [3:0] alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Chooses the source of each EX operand: the youngest in-flight producer of
// that register, or the value read from the register file.
module forward_unit
  import pipe_pkg::*;
#(
  parameter int ZERO_REG = pipe_pkg::ZERO_REG
) (
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       exmem_reg_write,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_reg_write,
  input  logic [4:0] memwb_rd,
  output fwd_sel_t   sel1,
  output fwd_sel_t   sel2
);

  // EX/MEM is checked first so it wins over MEM/WB on a shared destination.
  function automatic fwd_sel_t pick(input logic [4:0] src);
    fwd_sel_t sel;
    if (src == 5'(ZERO_REG)) begin
      sel = FWD_REG;
    end else if (exmem_reg_write && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  assign sel1 = pick(src1);
  assign sel2 = pick(src2);

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection and EX-stage operand
// forwarding from the EX/MEM and MEM/WB producers.
module ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int ZERO_REG = pipe_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_d1,
  input  logic [DATA_W-1:0] id_d2,
  input  logic [4:0]        id_src1,
  input  logic [4:0]        id_src2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  alu_op_t           id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output alu_op_t           ex_alu_op,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [DATA_W-1:0] ex_store_data
);

  logic              ex_alu_src;
  logic [4:0]        ex_src1;
  logic [4:0]        ex_src2;
  logic [DATA_W-1:0] ex_d1;
  logic [DATA_W-1:0] ex_d2;
  logic [DATA_W-1:0] ex_imm;
  logic              src2_used;
  fwd_sel_t          sel1;
  fwd_sel_t          sel2;
  logic [DATA_W-1:0] fwd_b;

  assign src2_used = !id_alu_src || id_mem_write || id_branch;

  // A load in EX whose destination feeds the ID instruction needs one bubble.
  always_comb begin
    stall = 1'b0;
    if (!reset && ex_valid && ex_mem_read && (ex_rd != 5'(ZERO_REG)) && id_valid) begin
      stall = (ex_rd == id_src1) || ((ex_rd == id_src2) && src2_used);
    end else begin
      stall = 1'b0;
    end
  end

  // Data fields keep loading during a bubble; only the control is killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_rd        <= 5'(ZERO_REG);
      ex_alu_op    <= 4'd0;
      ex_alu_src   <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_src1      <= 5'(ZERO_REG);
      ex_src2      <= 5'(ZERO_REG);
      ex_d1        <= '0;
      ex_d2        <= '0;
      ex_imm       <= '0;
    end else begin
      ex_rd      <= id_rd;
      ex_alu_op  <= id_alu_op;
      ex_alu_src <= id_alu_src;
      ex_src1    <= id_src1;
      ex_src2    <= id_src2;
      ex_d1      <= id_d1;
      ex_d2      <= id_d2;
      ex_imm     <= id_imm;
      if (flush || stall) begin
        ex_valid     <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_branch    <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_mem_read  <= id_mem_read;
        ex_mem_write <= id_mem_write;
        ex_reg_write <= id_reg_write;
        ex_branch    <= id_branch;
      end
    end
  end

  forward_unit #(.ZERO_REG(ZERO_REG)) u_fwd (
    .src1            (ex_src1),
    .src2            (ex_src2),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel1            (sel1),
    .sel2            (sel2)
  );

  function automatic logic [DATA_W-1:0] fwd_mux(input fwd_sel_t sel,
                                                input logic [DATA_W-1:0] reg_val);
    logic [DATA_W-1:0] val;
    case (sel)
      FWD_EXMEM: val = exmem_result;
      FWD_MEMWB: val = memwb_data;
      FWD_REG:   val = reg_val;
      default:   val = reg_val;
    endcase
    return val;
  endfunction

  assign ex_opa        = fwd_mux(sel1, ex_d1);
  assign fwd_b         = fwd_mux(sel2, ex_d2);
  assign ex_opb        = ex_alu_src ? ex_imm : fwd_b;
  assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized plus directed bench for ex_operand_stage against a behavioural
// model of the instruction sitting in EX.
module tb_ex_operand_stage;
  import pipe_pkg::*;

  localparam logic [4:0] ZR = 5'd31;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch;
  logic [63:0] id_d1, id_d2, id_imm;
  logic [4:0]  id_src1, id_src2, id_rd;
  alu_op_t     id_alu_op;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_data;
  logic        stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch;
  logic [4:0]  ex_rd;
  alu_op_t     ex_alu_op;
  logic [63:0] ex_opa, ex_opb, ex_store_data;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_d1(id_d1), .id_d2(id_d2),
    .id_src1(id_src1), .id_src2(id_src2), .id_rd(id_rd), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .stall(stall), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_opa(ex_opa),
    .ex_opb(ex_opb), .ex_store_data(ex_store_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of the instruction currently held in EX
  logic        m_valid, m_asrc, m_mr, m_mw, m_rw, m_br;
  logic [4:0]  m_rd, m_s1, m_s2;
  logic [3:0]  m_op;
  logic [63:0] m_d1, m_d2, m_imm;

  task automatic model_reset();
    m_valid = 1'b0; m_asrc = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_br = 1'b0;
    m_rd = ZR; m_s1 = ZR; m_s2 = ZR; m_op = 4'd0;
    m_d1 = 64'd0; m_d2 = 64'd0; m_imm = 64'd0;
  endtask

  function automatic logic [63:0] fwd_val(input logic [4:0] src, input logic [63:0] rv);
    if (src == ZR) return rv;
    if (exmem_reg_write && exmem_rd == src) return exmem_result;
    if (memwb_reg_write && memwb_rd == src) return memwb_data;
    return rv;
  endfunction

  function automatic logic exp_stall();
    logic uses2;
    uses2 = !id_alu_src || id_mem_write || id_branch;
    return m_valid && m_mr && (m_rd != ZR) && id_valid &&
           ((m_rd == id_src1) || ((m_rd == id_src2) && uses2));
  endfunction

  // Called just after inputs are driven at the falling edge; checks, then
  // advances the model to what the next rising edge will capture.
  task automatic check_and_step();
    logic s;
    #1;
    s = exp_stall();
    check_val("stall", {63'd0, stall}, {63'd0, s});
    check_val("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    check_val("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m_mr});
    check_val("ex_mem_write", {63'd0, ex_mem_write}, {63'd0, m_mw});
    check_val("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m_rw});
    check_val("ex_branch", {63'd0, ex_branch}, {63'd0, m_br});
    if (m_valid) begin
      check_val("ex_rd", {59'd0, ex_rd}, {59'd0, m_rd});
      check_val("ex_alu_op", {60'd0, ex_alu_op}, {60'd0, m_op});
      check_val("ex_opa", ex_opa, fwd_val(m_s1, m_d1));
      check_val("ex_opb", ex_opb, m_asrc ? m_imm : fwd_val(m_s2, m_d2));
      check_val("ex_store_data", ex_store_data, fwd_val(m_s2, m_d2));
    end
    m_rd = id_rd; m_op = id_alu_op; m_asrc = id_alu_src; m_s1 = id_src1; m_s2 = id_src2;
    m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm;
    if (flush || s) begin
      m_valid = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_br = 1'b0;
    end else begin
      m_valid = id_valid; m_mr = id_mem_read; m_mw = id_mem_write;
      m_rw = id_reg_write; m_br = id_branch;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_in();
    id_valid = 1'b0; id_alu_src = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_reg_write = 1'b0; id_branch = 1'b0; id_d1 = 64'd0; id_d2 = 64'd0; id_imm = 64'd0;
    id_src1 = 5'd0; id_src2 = 5'd0; id_rd = 5'd0; id_alu_op = 4'd0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 64'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 64'd0;
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 5))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      3: return ZR;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic drive_rand();
    id_valid = ($urandom_range(0, 7) != 0);
    id_d1 = {$urandom, $urandom}; id_d2 = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_src1 = rnd_reg(); id_src2 = rnd_reg(); id_rd = rnd_reg();
    id_alu_op = 4'($urandom_range(0, 15));
    id_alu_src = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = ($urandom_range(0, 3) == 0); id_reg_write = 1'($urandom_range(0, 1));
    id_branch = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 9) == 0);
    exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd = rnd_reg(); exmem_result = {$urandom, $urandom};
    memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = rnd_reg(); memwb_data = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
    check_val({tag, "_ctrl"}, {59'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, stall}, 64'd0);
    check_val({tag, "_rd"}, {59'd0, ex_rd}, 64'd31);
    check_val({tag, "_opa"}, ex_opa, 64'd0);
    check_val({tag, "_store"}, ex_store_data, 64'd0);
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    exmem_reg_write = 1'b1; exmem_rd = ZR; exmem_result = 64'hFF;
    #2;
    check_reset_outputs("reset");
    tick(); tick();
    reset = 1'b0;
    model_reset();
    clear_in();

    // EX/MEM forwarding over stale register data
    id_valid = 1'b1; id_src1 = 5'd1; id_d1 = 64'h10; id_rd = 5'd5; id_reg_write = 1'b1;
    check_and_step(); tick();
    clear_in(); exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 64'h55;
    check_and_step();
    check_val("r033_opa", ex_opa, 64'h55);
    tick();

    // EX/MEM beats MEM/WB on the same register
    clear_in(); id_valid = 1'b1; id_src2 = 5'd2; id_d2 = 64'h01; id_rd = 5'd6;
    check_and_step(); tick();
    clear_in(); exmem_reg_write = 1'b1; exmem_rd = 5'd2; exmem_result = 64'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_data = 64'hBB;
    check_and_step();
    check_val("r034_opb", ex_opb, 64'hAA);
    tick();

    // Load-use: one bubble then the consumer enters
    clear_in(); id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd3; id_alu_src = 1'b1;
    check_and_step(); tick();
    clear_in(); id_valid = 1'b1; id_src1 = 5'd3; id_src2 = 5'd4; id_rd = 5'd7; id_reg_write = 1'b1;
    check_and_step();
    check_val("r035_stall", {63'd0, stall}, 64'd1);
    tick();
    check_and_step();
    check_val("r035_stall_clear", {63'd0, stall}, 64'd0);
    check_val("r035_bubble", {63'd0, ex_valid}, 64'd0);
    tick();
    clear_in();
    check_and_step();
    check_val("r035_enter", {63'd0, ex_valid}, 64'd1);
    tick();

    // XZR is neither forwarded nor stalled on
    clear_in(); id_valid = 1'b1; id_src1 = ZR; id_rd = 5'd8;
    check_and_step(); tick();
    clear_in(); exmem_reg_write = 1'b1; exmem_rd = ZR; exmem_result = 64'hFF;
    memwb_reg_write = 1'b1; memwb_rd = ZR; memwb_data = 64'hFF;
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = ZR; id_alu_src = 1'b1;
    check_and_step();
    check_val("r036_opa", ex_opa, 64'd0);
    tick();
    clear_in(); id_valid = 1'b1; id_src1 = ZR; id_src2 = ZR;
    check_and_step();
    check_val("r036_stall", {63'd0, stall}, 64'd0);
    tick();

    // Store: immediate on opb, forwarded value on store data
    clear_in(); id_valid = 1'b1; id_mem_write = 1'b1; id_alu_src = 1'b1; id_src2 = 5'd4; id_imm = 64'd8;
    check_and_step(); tick();
    clear_in(); exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 64'h1234;
    check_and_step();
    check_val("r037_opb", ex_opb, 64'd8);
    check_val("r037_store", ex_store_data, 64'h1234);
    tick();

    // Flush during a stall, then reset arriving mid-stall
    clear_in(); id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd6; id_alu_src = 1'b1;
    check_and_step(); tick();
    clear_in(); id_valid = 1'b1; id_src1 = 5'd6; flush = 1'b1;
    check_and_step();
    check_val("r038_stall_flush", {63'd0, stall}, 64'd1);
    tick();
    clear_in(); id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd9; id_alu_src = 1'b1;
    check_and_step(); tick();
    clear_in(); id_valid = 1'b1; id_src1 = 5'd9;
    #1;
    check_val("r038_pre_stall", {63'd0, stall}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("r038_reset");
    tick();
    reset = 1'b0;
    model_reset();
    clear_in();

    for (int i = 0; i < 400; i++) begin
      drive_rand();
      check_and_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter: DATA_W, 64, operand and result width.
REQ-002 Parameter: ZERO_REG, 31, register number hardwired to zero (XZR); never forwarded, never stalled on.
REQ-003 clk  in  1  the single pipeline clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_d1, id_d2  in  DATA_W each  register-file read data for first and second source.
REQ-007 id_src1, id_src2  in  5 each  source register numbers; id_src2 is the register actually read on port 2, after Rm/Rd selection.
REQ-008 id_rd  in  5  destination register.
REQ-009 id_imm  in  DATA_W  sign-extended immediate.
REQ-010 id_alu_op  in  4, id_alu_src  in  1, id_mem_read  in  1, id_mem_write  in  1, id_reg_write  in  1, id_branch  in  1  decoded control.
REQ-011 flush  in  1  taken branch; kill the instruction entering EX.
REQ-012 exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  DATA_W  EX/MEM producer.
REQ-013 memwb_reg_write  in  1, memwb_rd  in  5, memwb_data  in  DATA_W  MEM/WB producer.
REQ-014 stall  out  1  load-use hazard; hold PC and IF/ID this cycle.
REQ-015 ex_valid  out  1, ex_rd  out  5, ex_alu_op  out  4, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch  out  1 each  registered control.
REQ-016 ex_opa  out  DATA_W  forwarded first ALU operand.
REQ-017 ex_opb  out  DATA_W  second ALU operand (ex_imm if ex_alu_src, else forwarded source 2).
REQ-018 ex_store_data  out  DATA_W  forwarded source 2, regardless of alu_src.

Function
REQ-019 ID/EX register SHALL capture all id_* fields on each rising clk; latency ID->EX is exactly one cycle.
REQ-020 Load priority each edge SHALL be: reset > flush > stall > normal load.
REQ-021 On flush or stall the register SHALL load a bubble: ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=ex_branch=0; data fields don't-care.
REQ-022 stall SHALL be combinational: 1 iff ex_valid & ex_mem_read & ex_rd!=ZERO_REG & id_valid & (ex_rd==id_src1 | (ex_rd==id_src2 & src2 used)); src2 used = !id_alu_src | id_mem_write | id_branch.
REQ-023 Forwarding per source SHALL select EXMEM when exmem_reg_write & exmem_rd==src & src!=ZERO_REG, else MEMWB when memwb_reg_write & memwb_rd==src & src!=ZERO_REG, else registered read data.
REQ-024 EXMEM SHALL win when both producers match the same register (youngest value).
REQ-025 Forwarding SHALL be combinational on the registered source numbers during the EX cycle; no extra latency.
REQ-026 A source equal to ZERO_REG SHALL produce the registered read data (zero) regardless of producers.
REQ-027 stall and flush asserted together: flush governs ID/EX (bubble); stall output still reflects REQ-022.
REQ-028 Stall lasts exactly one cycle per load-use pair, since the bubble clears ex_mem_read.

Reset
REQ-029 reset SHALL asynchronously clear the ID/EX register to a bubble: ex_valid=0, all control 0, ex_rd=ZERO_REG, data fields 0.
REQ-030 With reset asserted stall SHALL read 0; reset mid-stall discards the stalled pair.

Structure
REQ-031 Shared package pipe_pkg SHALL hold DATA_W, ZERO_REG, the alu_op type, and fwd_sel_t enum {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
REQ-032 One sub-module forward_unit SHALL compute fwd_sel_t for both sources; hazard detection and ID/EX register stay in the top.

Verification
REQ-033 ADD X1 in EX/MEM (exmem_rd=1, result 0x55), EX reads X1 with stale 0x10 -> ex_opa=0x55.
REQ-034 EX/MEM rd=2 result 0xAA and MEM/WB rd=2 data 0xBB, EX src2=2, alu_src=0 -> ex_opb=0xAA.
REQ-035 LDUR X3 in EX, ID ADD src1=3 -> stall=1 one cycle, next ex_valid=0, following cycle ADD enters with stall=0.
REQ-036 Producers write X31 with 0xFF, EX src1=31 -> ex_opa=0, and LDUR X31 followed by use of X31 -> stall=0.
REQ-037 STUR with alu_src=1, src2=4, EX/MEM rd=4 result 0x1234, imm=8 -> ex_opb=8, ex_store_data=0x1234.
REQ-038 flush during stall, then reset mid-cycle -> ex_valid=0 immediately on reset, all outputs at REQ-029 values.
